// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse protocol constants, controller state encoding and the init command ROM.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;
  localparam logic [7:0] MOUSE_ID     = 8'h00;

  typedef enum logic [3:0] {
    SEND     = 4'd0,
    WAIT_ACK = 4'd1,
    WAIT_BAT = 4'd2,
    WAIT_ID  = 4'd3,
    STR_B0   = 4'd4,
    STR_B1   = 4'd5,
    STR_B2   = 4'd6,
    FAIL     = 4'd7
  } state_t;

  function automatic logic [7:0] cmd_rom(input logic [1:0] idx, input logic [7:0] rate);
    case (idx)
      2'd0:    return CMD_RESET;
      2'd1:    return CMD_SET_RATE;
      2'd2:    return rate;
      default: return CMD_ENABLE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_pkt_assembler.sv
// Stream-mode packet framer: syncs on bit3 of byte 0, drops partial packets after an idle gap.
module ps2_pkt_assembler #(
  parameter int PKT_GAP = 250_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_pkt_valid,
  output logic       o_lefbut,
  output logic       o_rigbut,
  output logic       o_midbut,
  output logic [8:0] o_x_mov,
  output logic [8:0] o_y_mov,
  output logic [1:0] o_ovf,
  output logic [1:0] o_phase
);

  localparam logic [25:0] LD_GAP = 26'(PKT_GAP);

  logic [1:0]  r_phase;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;
  logic [25:0] r_gap;
  logic        r_pkt_valid;
  logic        r_lef;
  logic        r_rig;
  logic        r_mid;
  logic [8:0]  r_x;
  logic [8:0]  r_y;
  logic [1:0]  r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase     <= 2'd0;
      r_pkt_valid <= 1'b0;
      r_lef       <= 1'b0;
      r_rig       <= 1'b0;
      r_mid       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_ovf       <= '0;
    end else begin
      r_pkt_valid <= 1'b0;
      if (!i_en) begin
        r_phase <= 2'd0;
      end else begin
        case (r_phase)
          2'd0: if (i_rx_valid && i_rx_data[3]) begin
            r_b0    <= i_rx_data;
            r_gap   <= LD_GAP;
            r_phase <= 2'd1;
          end
          2'd1: if (i_rx_valid) begin
            r_b1    <= i_rx_data;
            r_gap   <= LD_GAP;
            r_phase <= 2'd2;
          end else if (r_gap == '0) begin
            r_phase <= 2'd0;
          end else begin
            r_gap <= r_gap - 26'd1;
          end
          2'd2: if (i_rx_valid) begin
            // sign bits of the 9-bit deltas live in byte 0
            r_lef       <= r_b0[0];
            r_rig       <= r_b0[1];
            r_mid       <= r_b0[2];
            r_x         <= {r_b0[4], r_b1};
            r_y         <= {r_b0[5], i_rx_data};
            r_ovf       <= {r_b0[7], r_b0[6]};
            r_pkt_valid <= 1'b1;
            r_phase     <= 2'd0;
          end else if (r_gap == '0) begin
            r_phase <= 2'd0;
          end else begin
            r_gap <= r_gap - 26'd1;
          end
          default: r_phase <= 2'd0;
        endcase
      end
    end
  end

  assign o_pkt_valid = r_pkt_valid;
  assign o_lefbut    = r_lef;
  assign o_rigbut    = r_rig;
  assign o_midbut    = r_mid;
  assign o_x_mov     = r_x;
  assign o_y_mov     = r_y;
  assign o_ovf       = r_ovf;
  assign o_phase     = r_phase;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init sequencer (reset, BAT, ID, sample rate, enable) with retry handling,
// handing over to the stream packet assembler once reporting is enabled.
module ps2_mouse_ctrl
  import ps2_pkg::*;
#(
  parameter int         ACK_TIMEOUT = 1_000_000,
  parameter int         BAT_TIMEOUT = 37_500_000,
  parameter int         PKT_GAP     = 250_000,
  parameter int         MAX_RETRY   = 3,
  parameter logic [7:0] SAMPLE_RATE = 8'd100
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic       iSTART,
  output logic [7:0] oTX_DATA,
  output logic       oTX_REQ,
  input  logic       iTX_DONE,
  input  logic       iTX_ERR,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  output logic       oINIT_DONE,
  output logic       oINIT_FAIL,
  output logic       oPKT_VALID,
  output logic       oLEFBUT,
  output logic       oRIGBUT,
  output logic       oMIDBUT,
  output logic [8:0] oX_MOV,
  output logic [8:0] oY_MOV,
  output logic [1:0] oOVF,
  output logic [3:0] oSTATE
);

  localparam logic [25:0] LD_ACK    = 26'(ACK_TIMEOUT);
  localparam logic [25:0] LD_BAT    = 26'(BAT_TIMEOUT);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [3:0]  r_retry;
  logic [25:0] r_cnt;
  logic        r_tx_req;
  logic [7:0]  r_tx_data;
  logic        r_init_done;
  logic        r_init_fail;
  logic        w_retry;
  logic        w_idx0;
  logic        w_asm_en;
  logic [1:0]  w_phase;
  logic [3:0]  w_state;

  // A received byte always takes precedence over a timer expiring in the same cycle.
  always_comb begin
    w_retry = 1'b0;
    w_idx0  = 1'b0;
    case (r_state)
      SEND:     w_retry = r_tx_req & iTX_ERR;
      WAIT_ACK: w_retry = iRX_VALID ? (iRX_DATA != RSP_ACK) : (r_cnt == '0);
      WAIT_BAT: begin
        w_retry = iRX_VALID ? (iRX_DATA == RSP_BAT_ERR) : (r_cnt == '0);
        w_idx0  = 1'b1;
      end
      WAIT_ID: begin
        w_retry = iRX_VALID ? (iRX_DATA != MOUSE_ID) : (r_cnt == '0);
        w_idx0  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      r_state     <= SEND;
      r_idx       <= 2'd0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_tx_req    <= 1'b1;
      r_tx_data   <= CMD_RESET;
      r_init_done <= 1'b0;
      r_init_fail <= 1'b0;
    end else if (iSTART) begin
      r_state     <= SEND;
      r_idx       <= 2'd0;
      r_retry     <= '0;
      r_tx_req    <= 1'b0;
      r_init_done <= 1'b0;
      r_init_fail <= 1'b0;
    end else if (w_retry) begin
      r_tx_req <= 1'b0;
      if (w_idx0) r_idx <= 2'd0;
      if (r_retry == RETRY_MAX) begin
        r_state     <= FAIL;
        r_init_fail <= 1'b1;
      end else begin
        r_retry <= r_retry + 4'd1;
        r_state <= SEND;
      end
    end else begin
      case (r_state)
        SEND: if (!r_tx_req) begin
          r_tx_req  <= 1'b1;
          r_tx_data <= cmd_rom(r_idx, SAMPLE_RATE);
        end else if (iTX_DONE) begin
          r_tx_req <= 1'b0;
          r_cnt    <= LD_ACK;
          r_state  <= WAIT_ACK;
        end
        WAIT_ACK: if (iRX_VALID) begin
          r_retry <= '0;
          if (r_idx == 2'd0) begin
            r_cnt   <= LD_BAT;
            r_state <= WAIT_BAT;
          end else if (r_idx == 2'd3) begin
            r_init_done <= 1'b1;
            r_state     <= STR_B0;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= SEND;
          end
        end else begin
          r_cnt <= r_cnt - 26'd1;
        end
        WAIT_BAT: if (iRX_VALID) begin
          if (iRX_DATA == RSP_BAT_OK) begin
            r_cnt   <= LD_BAT;
            r_state <= WAIT_ID;
          end
        end else begin
          r_cnt <= r_cnt - 26'd1;
        end
        WAIT_ID: if (iRX_VALID) begin
          r_idx   <= 2'd1;
          r_state <= SEND;
        end else begin
          r_cnt <= r_cnt - 26'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_asm_en = r_init_done & ~iSTART;

  ps2_pkt_assembler #(
    .PKT_GAP (PKT_GAP)
  ) u_asm (
    .i_clk       (iCLK_50),
    .i_rst       (iRST),
    .i_en        (w_asm_en),
    .i_rx_data   (iRX_DATA),
    .i_rx_valid  (iRX_VALID),
    .o_pkt_valid (oPKT_VALID),
    .o_lefbut    (oLEFBUT),
    .o_rigbut    (oRIGBUT),
    .o_midbut    (oMIDBUT),
    .o_x_mov     (oX_MOV),
    .o_y_mov     (oY_MOV),
    .o_ovf       (oOVF),
    .o_phase     (w_phase)
  );

  // Streaming is one controller state; the assembler phase selects STR_B0/B1/B2.
  assign w_state    = r_state;
  assign oSTATE     = (r_state == STR_B0) ? (w_state | {2'b00, w_phase}) : w_state;
  assign oTX_REQ    = r_tx_req;
  assign oTX_DATA   = r_tx_data;
  assign oINIT_DONE = r_init_done;
  assign oINIT_FAIL = r_init_fail;

endmodule
